// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID-stage pipeline control and the hazard unit.
// Every signal is a plain per-cycle level: there is no valid/ready handshake.
// The pipeline presents its stage fields each cycle, and the hazard unit
// returns that cycle's stall/bubble/freeze decisions combinationally in the
// same cycle. The master modport belongs to the pipeline side and the slave
// modport to hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [31:0]       if_id_instr_i;
  logic              id_ex_memrd_i;
  logic              id_ex_regwrite_i;
  logic [REG_AW-1:0] id_ex_wraddr_i;
  logic              ex_mem_memrd_i;
  logic [REG_AW-1:0] ex_mem_wraddr_i;
  logic              mem_stall_i;
  logic              cnt_clr_i;
  logic              pc_stall_o;
  logic              if_id_hold_o;
  logic              bubble_o;
  logic              freeze_o;
  logic [CNT_W-1:0]  bubble_cnt_o;
  logic              dbg_state_o;   // 0 = IDLE, 1 = STALL

  modport master (
    output if_id_instr_i, id_ex_memrd_i, id_ex_regwrite_i, id_ex_wraddr_i,
           ex_mem_memrd_i, ex_mem_wraddr_i, mem_stall_i, cnt_clr_i,
    input  pc_stall_o, if_id_hold_o, bubble_o, freeze_o, bubble_cnt_o,
           dbg_state_o
  );

  modport slave (
    input  if_id_instr_i, id_ex_memrd_i, id_ex_regwrite_i, id_ex_wraddr_i,
           ex_mem_memrd_i, ex_mem_wraddr_i, mem_stall_i, cnt_clr_i,
    output pc_stall_o, if_id_hold_o, bubble_o, freeze_o, bubble_cnt_o,
           dbg_state_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection unit for the 5-stage MIPS pipeline.
// This unit detects load-use hazards and, when branches resolve in ID, branch
// operand hazards. A multi-cycle stall is held with a countdown. A data-memory
// wait freezes the whole pipeline. Bubble cycles are counted with saturation.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_ID    = 1,
  parameter int CNT_W    = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  // rem has to hold up to LOAD_LAT (the largest stall need is LOAD_LAT+1).
  localparam int REM_W = $clog2(LOAD_LAT + 2);
  localparam logic [REM_W-1:0] N_ONE  = REM_W'(1);
  localparam logic [REM_W-1:0] N_LOAD = REM_W'(LOAD_LAT);
  localparam logic [REM_W-1:0] N_BRLD = REM_W'(LOAD_LAT + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [REM_W-1:0]  rem, rem_n;
  logic [REM_W-1:0]  need_n;
  logic [CNT_W-1:0]  cnt;
  logic              stall_raw, bubble_raw, freeze_raw;

  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt;
  logic              rt_src, is_br, ex_match, mem_match;

  // Instruction decode. rt is read only by R-type, beq, bne and sw.
  assign op     = hz.if_id_instr_i[31:26];
  assign rs     = REG_AW'(hz.if_id_instr_i[25:21]);
  assign rt     = REG_AW'(hz.if_id_instr_i[20:16]);
  assign rt_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
  assign is_br  = (op == 6'h04) || (op == 6'h05);

  // A write to $0 is architecturally discarded, so it can never create a hazard.
  assign ex_match  = (hz.id_ex_wraddr_i != '0) &&
                     ((hz.id_ex_wraddr_i == rs) || (rt_src && (hz.id_ex_wraddr_i == rt)));
  assign mem_match = (hz.ex_mem_wraddr_i != '0) &&
                     ((hz.ex_mem_wraddr_i == rs) || (rt_src && (hz.ex_mem_wraddr_i == rt)));

  // Stall need for the current ID instruction: maximum over all active conditions.
  always_comb begin
    need_n = '0;
    if (hz.id_ex_memrd_i && ex_match)
      need_n = N_LOAD;
    if ((BR_ID != 0) && is_br) begin
      if (hz.id_ex_regwrite_i && ex_match && (need_n < N_ONE))
        need_n = N_ONE;
      if (hz.id_ex_memrd_i && ex_match)
        need_n = N_BRLD;
      if (hz.ex_mem_memrd_i && mem_match && (need_n < N_ONE))
        need_n = N_ONE;
    end
  end

  // State and countdown registers; reset aborts any stall in progress.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  // Next-state and raw stall decisions; a memory freeze holds everything.
  always_comb begin
    state_n    = state;
    rem_n      = rem;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    freeze_raw = 1'b0;
    if (hz.mem_stall_i) begin
      freeze_raw = 1'b1;
      stall_raw  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (need_n != '0) begin
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
            if (need_n > N_ONE) begin
              state_n = S_STALL;
              rem_n   = need_n - N_ONE;
            end
          end
        end
        S_STALL: begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
          rem_n      = rem - N_ONE;
          if (rem == N_ONE)
            state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
          rem_n   = '0;
        end
      endcase
    end
  end

  // Saturating bubble counter; a clear beats a coincident increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      cnt <= '0;
    else if (hz.cnt_clr_i)
      cnt <= '0;
    else if (bubble_raw && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + CNT_W'(1);
  end

  // Control outputs are forced low for as long as reset is asserted.
  assign hz.pc_stall_o   = rst_i & stall_raw;
  assign hz.if_id_hold_o = rst_i & stall_raw;
  assign hz.bubble_o     = rst_i & bubble_raw;
  assign hz.freeze_o     = rst_i & freeze_raw;
  assign hz.bubble_cnt_o = cnt;
  assign hz.dbg_state_o  = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. It runs two instances on the same stimulus:
// u_dut1 has LOAD_LAT=1 and CNT_W=4, and u_dut2 has LOAD_LAT=2 and CNT_W=16.
// Each stimulus vector carries hand-computed stall/bubble/freeze/state values
// for both instances.
module tb_hazard_ctrl;
  localparam int W = 21;  // {pc_stall, hold, bubble, freeze, state, cnt[15:0]}

  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_ADD  = 32'h0102_4820;  // add $9,$8,$2
  localparam logic [31:0] I_BEQ  = 32'h1085_0000;  // beq $4,$5
  localparam logic [31:0] I_BEQ0 = 32'h1000_0000;  // beq $0,$0
  localparam logic [31:0] I_SW   = 32'hAFA8_0000;  // sw  $8,0($29)
  localparam logic [31:0] I_LW38 = 32'h8D03_0000;  // lw  $3,0($8)

  // Expected codes: {stall(pc & hold), bubble, freeze, state}
  localparam logic [3:0] E_IDL = 4'b0000;
  localparam logic [3:0] E_BUB = 4'b1100;
  localparam logic [3:0] E_BST = 4'b1101;
  localparam logic [3:0] E_FRZ = 4'b1010;
  localparam logic [3:0] E_FST = 4'b1011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if1 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if2 ();

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_ID(1), .CNT_W(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .hz(if1.slave));
  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .BR_ID(1), .CNT_W(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst_n), .hz(if2.slave));

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp2_q[$];
  int           id1_q[$];
  int           id2_q[$];
  int checks = 0;
  int errors = 0;
  int vid = 0;
  int m1 = 0;
  int m2 = 0;

  function automatic logic [W-1:0] act1();
    return {if1.pc_stall_o, if1.if_id_hold_o, if1.bubble_o, if1.freeze_o,
            if1.dbg_state_o, 12'd0, if1.bubble_cnt_o};
  endfunction

  function automatic logic [W-1:0] act2();
    return {if2.pc_stall_o, if2.if_id_hold_o, if2.bubble_o, if2.freeze_o,
            if2.dbg_state_o, if2.bubble_cnt_o};
  endfunction

  // driver: applies one cycle of inputs at posedge+1 and queues the expected response
  task automatic vec(input logic [31:0] instr, input logic ld, input logic rw,
                     input logic [4:0] wa, input logic mld, input logic [4:0] mwa,
                     input logic ms, input logic clr,
                     input logic [3:0] e1, input logic [3:0] e2);
    if1.if_id_instr_i = instr;  if2.if_id_instr_i = instr;
    if1.id_ex_memrd_i = ld;     if2.id_ex_memrd_i = ld;
    if1.id_ex_regwrite_i = rw;  if2.id_ex_regwrite_i = rw;
    if1.id_ex_wraddr_i = wa;    if2.id_ex_wraddr_i = wa;
    if1.ex_mem_memrd_i = mld;   if2.ex_mem_memrd_i = mld;
    if1.ex_mem_wraddr_i = mwa;  if2.ex_mem_wraddr_i = mwa;
    if1.mem_stall_i = ms;       if2.mem_stall_i = ms;
    if1.cnt_clr_i = clr;        if2.cnt_clr_i = clr;
    if (!rst_n) begin
      m1 = 0;
      m2 = 0;
    end
    exp1_q.push_back({e1[3], e1[3], e1[2], e1[1], e1[0], 16'(m1)});
    exp2_q.push_back({e2[3], e2[3], e2[2], e2[1], e2[0], 16'(m2)});
    id1_q.push_back(vid);
    id2_q.push_back(vid);
    vid++;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (clr) m1 = 0;
      else if (e1[2] && m1 != 15) m1 = m1 + 1;
      if (clr) m2 = 0;
      else if (e2[2] && m2 != 65535) m2 = m2 + 1;
    end else begin
      m1 = 0;
      m2 = 0;
    end
  endtask

  // monitor / scoreboard: compares the DUT outputs on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    int id;
    if (exp1_q.size() > 0) begin
      e = exp1_q.pop_front();
      id = id1_q.pop_front();
      checks++;
      if (act1() !== e) begin
        errors++;
        $display("FAIL dut1 step %0d: got %b expected %b", id, act1(), e);
      end
    end
    if (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      id = id2_q.pop_front();
      checks++;
      if (act2() !== e) begin
        errors++;
        $display("FAIL dut2 step %0d: got %b expected %b", id, act2(), e);
      end
    end
  end

  initial begin
    if1.if_id_instr_i = '0; if1.id_ex_memrd_i = 1'b0; if1.id_ex_regwrite_i = 1'b0;
    if1.id_ex_wraddr_i = '0; if1.ex_mem_memrd_i = 1'b0; if1.ex_mem_wraddr_i = '0;
    if1.mem_stall_i = 1'b0; if1.cnt_clr_i = 1'b0;
    if2.if_id_instr_i = '0; if2.id_ex_memrd_i = 1'b0; if2.id_ex_regwrite_i = 1'b0;
    if2.id_ex_wraddr_i = '0; if2.ex_mem_memrd_i = 1'b0; if2.ex_mem_wraddr_i = '0;
    if2.mem_stall_i = 1'b0; if2.cnt_clr_i = 1'b0;
    @(posedge clk);
    #1;

    // outputs held low in reset even with a hazard present
    vec(I_ADD, 1, 1, 8, 0, 0, 0, 0, E_IDL, E_IDL);
    vec(I_ADD, 1, 1, 8, 0, 0, 0, 0, E_IDL, E_IDL);
    rst_n = 1'b1;

    // load-use: EX lw $8, ID add $9,$8,$2
    vec(I_ADD, 1, 1, 8, 0, 0, 0, 0, E_BUB, E_BUB);
    vec(I_ADD, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_BST);
    vec(I_ADD, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_IDL);
    // rt of lw is not a source; rt of add is
    vec(I_LW38, 1, 1, 3, 0, 0, 0, 0, E_IDL, E_IDL);
    vec(I_ADD, 1, 1, 2, 0, 0, 0, 0, E_BUB, E_BUB);
    vec(I_NOP, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_BST);
    // destination $0 never matches
    vec(I_BEQ0, 1, 1, 0, 1, 0, 0, 0, E_IDL, E_IDL);

    // branch: EX lw $4, ID beq $4,$5 -> LOAD_LAT+1 cycles
    vec(I_BEQ, 1, 1, 4, 0, 0, 0, 0, E_BUB, E_BUB);
    vec(I_BEQ, 0, 0, 0, 1, 4, 0, 0, E_BST, E_BST);
    vec(I_BEQ, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_BST);
    vec(I_BEQ, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_IDL);
    // MEM load to the branch rt -> 1 cycle
    vec(I_BEQ, 0, 0, 0, 1, 5, 0, 0, E_BUB, E_BUB);
    vec(I_NOP, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_IDL);
    // EX ALU write of $4 with ID beq $4 -> 1 cycle
    vec(I_BEQ, 0, 1, 4, 0, 0, 0, 0, E_BUB, E_BUB);
    vec(I_NOP, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_IDL);

    // freeze for 3 cycles in the middle of a stall
    vec(I_BEQ, 1, 1, 4, 0, 0, 0, 0, E_BUB, E_BUB);
    for (int i = 0; i < 3; i++)
      vec(I_NOP, 0, 0, 0, 0, 0, 1, 0, E_FST, E_FST);
    vec(I_NOP, 0, 0, 0, 0, 0, 0, 0, E_BST, E_BST);
    vec(I_NOP, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_BST);
    vec(I_NOP, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_IDL);
    // freeze while in IDLE masks a pending hazard
    vec(I_ADD, 1, 1, 8, 0, 0, 1, 0, E_FRZ, E_FRZ);
    vec(I_ADD, 1, 1, 8, 0, 0, 0, 0, E_BUB, E_BUB);

    // asynchronous reset in the middle of the dut2 stall
    rst_n = 1'b0;
    #1;
    checks++;
    if (act1() !== '0) begin
      errors++;
      $display("FAIL async_rst dut1: got %b expected %b", act1(), {W{1'b0}});
    end
    checks++;
    if (act2() !== '0) begin
      errors++;
      $display("FAIL async_rst dut2: got %b expected %b", act2(), {W{1'b0}});
    end
    vec(I_ADD, 1, 1, 8, 0, 0, 0, 0, E_IDL, E_IDL);
    rst_n = 1'b1;
    // ID sw $8 with EX lw $8 stalls normally after reset
    vec(I_SW, 1, 0, 8, 0, 0, 0, 0, E_BUB, E_BUB);
    vec(I_SW, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_BST);
    vec(I_NOP, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_IDL);

    // continuous bubbles: the 4-bit counter saturates at 15
    for (int i = 0; i < 18; i++)
      vec(I_ADD, 1, 1, 8, 0, 0, 0, 0, E_BUB, (i % 2 == 0) ? E_BUB : E_BST);
    // clear together with a bubble -> 0
    vec(I_ADD, 1, 1, 8, 0, 0, 0, 1, E_BUB, E_BUB);
    vec(I_NOP, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_BST);
    vec(I_NOP, 0, 0, 0, 0, 0, 0, 0, E_IDL, E_IDL);

    @(negedge clk);
    if (exp1_q.size() != 0 || exp2_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", exp1_q.size() + exp2_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
